hdb3_decoder: RTL and testbench

Receive-side line decoder that sits directly downstream of the bipolar P/N line encoder. It consumes the encoder's registered P/N rail pair and recovers the original NRZ `data` stream. It removes HDB3 substitution codes (000V / B00V) and flags line-code errors. A saturating counter reports the number of error events to the monitoring logic.

---
 rtl/line_code_pkg.sv | 19 +
 rtl/hdb3_slot_classify.sv | 19 +
 rtl/hdb3_decoder.sv | 106 ++++++++++
 tb/tb_hdb3_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/line_code_pkg.sv
// Shared line-code definitions for the bipolar encoder/decoder pair and their benches.
package line_code_pkg;

   localparam logic POL_POS = 1'b1;
   localparam logic POL_NEG = 1'b0;
   localparam int   HDB3_RUN = 4;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      MARK    = 2'd1,
      VIOL    = 2'd2,
      CODEERR = 2'd3
   } slot_t;

   function automatic logic is_pulse(input slot_t s);
      return (s == MARK) || (s == VIOL);
   endfunction

endpackage

// File: rtl/hdb3_slot_classify.sv
// Combinational classification of one P/N line slot against the last pulse polarity.
module hdb3_slot_classify
   import line_code_pkg::*;
(
   input  logic  i_p,
   input  logic  i_n,
   input  logic  i_last_pol,
   output slot_t o_slot
);

   always_comb begin
      o_slot = EMPTY;
      if (i_p & i_n)
         o_slot = CODEERR;
      else if (i_p ^ i_n)
         o_slot = (i_p != i_last_pol) ? MARK : VIOL;
   end

endmodule

// File: rtl/hdb3_decoder.sv
// HDB3 line decoder: P/N rails to NRZ data, 4-slot latency, one slot per clock with no backpressure.
// Substitutions are erased in the shift window; code, violation and zero-run errors feed a saturating counter.
module hdb3_decoder
   import line_code_pkg::*;
#(
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             P,
   input  logic             N,
   output logic             data,
   output logic             valid,
   output logic             code_err,
   output logic             viol_err,
   output logic             zrun_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam logic [2:0] ZRUN_MAX = 3'(HDB3_RUN);

   slot_t            w_slot;
   logic             w_pulse;
   logic             w_is_v;
   logic             w_any_err;

   logic             r_last_pol;
   logic             r_last_v_pol;
   logic             r_v_seen;
   logic [3:0]       r_s;
   logic [2:0]       r_zrun;
   logic [2:0]       r_fill;
   logic             r_data;
   logic             r_valid;
   logic             r_code_err;
   logic             r_viol_err;
   logic             r_zrun_err;
   logic [ERR_W-1:0] r_err_cnt;

   hdb3_slot_classify u_classify (
      .i_p        (P),
      .i_n        (N),
      .i_last_pol (r_last_pol),
      .o_slot     (w_slot)
   );

   assign w_pulse   = is_pulse(w_slot);
   assign w_is_v    = (w_slot == VIOL);
   assign w_any_err = r_code_err | r_viol_err | r_zrun_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_last_pol   <= POL_NEG;
         r_last_v_pol <= POL_NEG;
         r_v_seen     <= 1'b0;
         r_s          <= 4'b0000;
         r_zrun       <= 3'd0;
         r_fill       <= 3'd0;
         r_data       <= 1'b0;
         r_valid      <= 1'b0;
         r_code_err   <= 1'b0;
         r_viol_err   <= 1'b0;
         r_zrun_err   <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         // A V wipes the whole window: it and the three slots before it were the substitution.
         if (w_is_v)
            r_s <= 4'b0000;
         else
            r_s <= {r_s[2:0], (w_slot == MARK)};
         r_data <= r_s[3];

         if (w_pulse)
            r_last_pol <= P;

         r_viol_err <= w_is_v && r_v_seen && (P == r_last_v_pol);
         if (w_is_v) begin
            r_v_seen     <= 1'b1;
            r_last_v_pol <= P;
         end

         r_code_err <= (w_slot == CODEERR);

         r_zrun_err <= !w_pulse && (r_zrun == ZRUN_MAX - 3'd1);
         if (w_pulse)
            r_zrun <= 3'd0;
         else if (r_zrun != ZRUN_MAX)
            r_zrun <= r_zrun + 3'd1;

         if (w_any_err && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + ERR_W'(1);

         if (r_fill != 3'd4)
            r_fill <= r_fill + 3'd1;
         r_valid <= r_valid | (r_fill == 3'd3);
      end
   end

   assign data     = r_data;
   assign valid    = r_valid;
   assign code_err = r_code_err;
   assign viol_err = r_viol_err;
   assign zrun_err = r_zrun_err;
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Bench for hdb3_decoder: directed HDB3 scenarios plus random slots against a slot-history reference model.
module tb_hdb3_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       P, N;
   logic       data, valid, code_err, viol_err, zrun_err;
   logic [7:0] err_cnt;

   int compared   = 0;
   int mismatched = 0;

   hdb3_decoder #(.ERR_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .P        (P),
      .N        (N),
      .data     (data),
      .valid    (valid),
      .code_err (code_err),
      .viol_err (viol_err),
      .zrun_err (zrun_err),
      .err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: dec[i] is the decoded bit of slot i+1 since reset release.
   int k;
   bit dec[$];
   bit m_last_pol, m_v_seen, m_last_v_pol;
   int m_run, m_errs;
   bit exp_data, exp_valid, exp_code, exp_viol, exp_zrun;
   int exp_cnt;

   task automatic model_clear();
      k = 0;
      dec.delete();
      m_last_pol = 0; m_v_seen = 0; m_last_v_pol = 0;
      m_run = 0; m_errs = 0;
   endtask

   // s: 0 empty, 1 positive pulse, 2 negative pulse, 3 both rails high
   task automatic drive_slot(input int s);
      bit p, n, pulse, is_v;
      p = (s == 1) || (s == 3);
      n = (s == 2) || (s == 3);
      P = p; N = n;
      @(posedge clk); #1;
      k++;
      exp_cnt  = (m_errs > 255) ? 255 : m_errs;
      pulse    = p ^ n;
      is_v     = pulse && (p == m_last_pol);
      exp_code = p & n;
      exp_viol = is_v && m_v_seen && (p == m_last_v_pol);
      if (pulse) m_run = 0; else m_run++;
      exp_zrun = (m_run == 4);
      dec.push_back(pulse && !is_v);
      if (is_v)
         for (int j = 0; j < 4; j++)
            if (dec.size() > j) dec[dec.size() - 1 - j] = 1'b0;
      if (pulse) m_last_pol = p;
      if (is_v) begin m_v_seen = 1; m_last_v_pol = p; end
      if (exp_code || exp_viol || exp_zrun) m_errs++;
      exp_data  = (k >= 5) ? dec[k - 5] : 1'b0;
      exp_valid = (k >= 4);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      reset = 1'b1; P = 1'b0; N = 1'b0;
      model_clear();
      @(posedge clk); #1;
      compared += 6;
      if (data !== 1'b0)     begin mismatched++; $display("FAIL reset data got %b want 0", data); end
      if (valid !== 1'b0)    begin mismatched++; $display("FAIL reset valid got %b want 0", valid); end
      if (code_err !== 1'b0) begin mismatched++; $display("FAIL reset code_err got %b want 0", code_err); end
      if (viol_err !== 1'b0) begin mismatched++; $display("FAIL reset viol_err got %b want 0", viol_err); end
      if (zrun_err !== 1'b0) begin mismatched++; $display("FAIL reset zrun_err got %b want 0", zrun_err); end
      if (err_cnt !== 8'd0)  begin mismatched++; $display("FAIL reset err_cnt got %0d want 0", err_cnt); end
      release_reset();
   endtask

   task automatic test_substitution();
      int seq[19] = '{1,0,0,0,1, 2,0,0,0,2, 1,0,0,1, 2,1,0,0,1};
      for (int i = 0; i < 19; i++) begin
         drive_slot(seq[i]);
         compared += 5;
         if (data !== exp_data)   begin mismatched++; $display("FAIL subst data slot %0d got %b want %b", k, data, exp_data); end
         if (valid !== exp_valid) begin mismatched++; $display("FAIL subst valid slot %0d got %b want %b", k, valid, exp_valid); end
         if (viol_err !== exp_viol) begin mismatched++; $display("FAIL subst viol_err slot %0d got %b want %b", k, viol_err, exp_viol); end
         if (zrun_err !== exp_zrun) begin mismatched++; $display("FAIL subst zrun_err slot %0d got %b want %b", k, zrun_err, exp_zrun); end
         if (err_cnt !== 8'(exp_cnt)) begin mismatched++; $display("FAIL subst err_cnt slot %0d got %0d want %0d", k, err_cnt, exp_cnt); end
         if (k == 5) begin
            compared++;
            if (data !== 1'b1) begin mismatched++; $display("FAIL subst first_mark data got %b want 1", data); end
         end
      end
      compared++;
      if (viol_err !== 1'b1) begin mismatched++; $display("FAIL subst b00v_viol got %b want 1", viol_err); end
   endtask

   task automatic test_code_zrun();
      int seq[9] = '{2,3,1,0,0,0,0,0,2};
      for (int i = 0; i < 9; i++) begin
         drive_slot(seq[i]);
         compared += 5;
         if (data !== exp_data)     begin mismatched++; $display("FAIL czr data slot %0d got %b want %b", k, data, exp_data); end
         if (code_err !== exp_code) begin mismatched++; $display("FAIL czr code_err slot %0d got %b want %b", k, code_err, exp_code); end
         if (viol_err !== exp_viol) begin mismatched++; $display("FAIL czr viol_err slot %0d got %b want %b", k, viol_err, exp_viol); end
         if (zrun_err !== exp_zrun) begin mismatched++; $display("FAIL czr zrun_err slot %0d got %b want %b", k, zrun_err, exp_zrun); end
         if (err_cnt !== 8'(exp_cnt)) begin mismatched++; $display("FAIL czr err_cnt slot %0d got %0d want %0d", k, err_cnt, exp_cnt); end
         if (i == 1 || i == 6) begin
            compared++;
            if ((i == 1 ? code_err : zrun_err) !== 1'b1) begin
               mismatched++; $display("FAIL czr pulse_at_%0d got 0 want 1", i);
            end
         end
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         drive_slot(3);
         compared += 2;
         if (code_err !== 1'b1) begin mismatched++; $display("FAIL sat code_err slot %0d got %b want 1", k, code_err); end
         if (err_cnt !== 8'(exp_cnt)) begin mismatched++; $display("FAIL sat err_cnt slot %0d got %0d want %0d", k, err_cnt, exp_cnt); end
      end
      drive_slot(m_last_pol ? 2 : 1);
      compared++;
      if (err_cnt !== 8'd255) begin mismatched++; $display("FAIL sat err_cnt_final got %0d want 255", err_cnt); end
   endtask

   task automatic test_midstream_reset();
      for (int i = 0; i < 6; i++) drive_slot(m_last_pol ? 2 : 1);
      compared++;
      if (data !== 1'b1) begin mismatched++; $display("FAIL mrst pre_data got %b want 1", data); end
      reset = 1'b1;
      #1;
      compared += 3;
      if (data !== 1'b0)    begin mismatched++; $display("FAIL mrst data got %b want 0", data); end
      if (valid !== 1'b0)   begin mismatched++; $display("FAIL mrst valid got %b want 0", valid); end
      if (err_cnt !== 8'd0) begin mismatched++; $display("FAIL mrst err_cnt got %0d want 0", err_cnt); end
      release_reset();
      for (int i = 0; i < 8; i++) begin
         drive_slot(i[0] ? 0 : 1);
         compared += 2;
         if (valid !== exp_valid) begin mismatched++; $display("FAIL mrst valid slot %0d got %b want %b", k, valid, exp_valid); end
         if (data !== exp_data)   begin mismatched++; $display("FAIL mrst data slot %0d got %b want %b", k, data, exp_data); end
      end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         drive_slot(r < 9 ? 0 : (r < 19 ? ($urandom_range(0, 1) ? 1 : 2) : 3));
         compared += 6;
         if (data !== exp_data)     begin mismatched++; $display("FAIL rand data slot %0d got %b want %b", k, data, exp_data); end
         if (valid !== exp_valid)   begin mismatched++; $display("FAIL rand valid slot %0d got %b want %b", k, valid, exp_valid); end
         if (code_err !== exp_code) begin mismatched++; $display("FAIL rand code_err slot %0d got %b want %b", k, code_err, exp_code); end
         if (viol_err !== exp_viol) begin mismatched++; $display("FAIL rand viol_err slot %0d got %b want %b", k, viol_err, exp_viol); end
         if (zrun_err !== exp_zrun) begin mismatched++; $display("FAIL rand zrun_err slot %0d got %b want %b", k, zrun_err, exp_zrun); end
         if (err_cnt !== 8'(exp_cnt)) begin mismatched++; $display("FAIL rand err_cnt slot %0d got %0d want %0d", k, err_cnt, exp_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_substitution();
      test_code_zrun();
      test_saturation();
      test_midstream_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
